// File: rtl/acc_multicycle_control.sv
// Multicycle Moore control FSM for the accumulator processor datapath.
// Sequences fetch, decode and execute and drives every datapath mux select
// and write enable from the current state and the latched opcode.
// Optional build macro CTRL_MEMWAIT_EN adds a MemReady input that stalls the
// memory-access states until the memory signals completion.

module acc_multicycle_control #(
    parameter int unsigned OPW     = 4,
    parameter int unsigned SP_STEP = 2
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic [OPW-1:0] Opcode,
`ifdef CTRL_MEMWAIT_EN
    input  logic           MemReady,
`endif
    output logic           PCWrite,
    output logic           Branch,
    output logic           BneOrBeq,
    output logic [1:0]     PCSrc,
    output logic           IRWrite,
    output logic           MemRead,
    output logic           MemWrite,
    output logic [1:0]     MemAddrSrc,
    output logic [2:0]     ACCSrc,
    output logic           ACCWrite,
    output logic           SPWrite,
    output logic           IOWrite,
    output logic [1:0]     ALUSrcA,
    output logic [2:0]     ALUSrcB,
    output logic [2:0]     ALUOp,
    output logic           Halted,
    output logic [3:0]     State
);

    // State codes; HALT shares code 0 with INIT and is told apart by halt_q.
    localparam logic [3:0] StInit    = 4'd0;
    localparam logic [3:0] StFetch   = 4'd1;
    localparam logic [3:0] StDecode  = 4'd2;
    localparam logic [3:0] StMemRd   = 4'd3;
    localparam logic [3:0] StExecMem = 4'd4;
    localparam logic [3:0] StMemWr   = 4'd5;
    localparam logic [3:0] StExecImm = 4'd6;
    localparam logic [3:0] StLoadImm = 4'd7;
    localparam logic [3:0] StBranch  = 4'd8;
    localparam logic [3:0] StJump    = 4'd9;
    localparam logic [3:0] StIoIn    = 4'd10;
    localparam logic [3:0] StIoOut   = 4'd11;
    localparam logic [3:0] StSpDec   = 4'd12;
    localparam logic [3:0] StPushWr  = 4'd13;
    localparam logic [3:0] StPopRd   = 4'd14;
    localparam logic [3:0] StPopWb   = 4'd15;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluOr  = 3'd3;

    // The ALU offers only const 2 and const 0; a zero step freezes SP.
    localparam logic [2:0] SrcBSpStep = (SP_STEP == 0) ? 3'd5 : 3'd0;

    localparam logic [OPW-1:0] OpLoad = OPW'(4);

    logic [3:0]     state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           halt_q, halt_d;
    logic           mem_ready;

`ifdef CTRL_MEMWAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // State, opcode and halt flag registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= StInit;
            op_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state logic; opcode is captured only while in DECODE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        halt_d  = halt_q;
        case (state_q)
            StInit:    if (!halt_q) state_d = StFetch;
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode: begin
                op_d = Opcode;
                case (Opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4: state_d = StMemRd;
                    4'h5:       state_d = StMemWr;
                    4'h6:       state_d = StExecImm;
                    4'h7:       state_d = StLoadImm;
                    4'h8, 4'h9: state_d = StBranch;
                    4'hA:       state_d = StJump;
                    4'hB:       state_d = StIoIn;
                    4'hC:       state_d = StIoOut;
                    4'hD:       state_d = StSpDec;
                    4'hE:       state_d = StPopRd;
                    default: begin
                        state_d = StInit;
                        halt_d  = 1'b1;
                    end
                endcase
            end
            StMemRd:   if (mem_ready) state_d = StExecMem;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StSpDec:   state_d = StPushWr;
            StPushWr:  if (mem_ready) state_d = StFetch;
            StPopRd:   if (mem_ready) state_d = StPopWb;
            default:   state_d = StFetch;
        endcase
    end

    // Moore decode of control outputs; anything not set in a state stays 0.
    always_comb begin
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BneOrBeq   = 1'b0;
        PCSrc      = 2'd0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemAddrSrc = 2'd0;
        ACCSrc     = 3'd0;
        ACCWrite   = 1'b0;
        SPWrite    = 1'b0;
        IOWrite    = 1'b0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 3'd0;
        ALUOp      = AluAdd;
        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                // PC and IR update only once the fetch data is valid.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode: begin
                // Precompute branch target PC + (imm << 1) into ALUOut.
                ALUSrcB = 3'd3;
            end
            StMemRd: begin
                MemAddrSrc = 2'd2;
                MemRead    = 1'b1;
            end
            StExecMem: begin
                ALUSrcA  = 2'd1;
                ALUSrcB  = 3'd1;
                ALUOp    = {1'b0, op_q[1:0]};
                ACCWrite = 1'b1;
                ACCSrc   = (op_q == OpLoad) ? 3'd1 : 3'd0;
            end
            StMemWr: begin
                MemAddrSrc = 2'd2;
                MemWrite   = 1'b1;
            end
            StExecImm: begin
                ALUSrcA  = 2'd1;
                ALUSrcB  = 3'd2;
                ACCWrite = 1'b1;
            end
            StLoadImm: begin
                ACCWrite = 1'b1;
                ACCSrc   = 3'd3;
            end
            StBranch: begin
                // ACC | 0 drives Zero so the PC block can qualify Branch.
                ALUSrcA  = 2'd1;
                ALUSrcB  = 3'd5;
                ALUOp    = AluOr;
                Branch   = 1'b1;
                BneOrBeq = op_q[0];
                PCSrc    = 2'd2;
            end
            StJump: begin
                PCWrite = 1'b1;
                PCSrc   = 2'd1;
            end
            StIoIn: begin
                ACCWrite = 1'b1;
                ACCSrc   = 3'd2;
            end
            StIoOut: begin
                IOWrite = 1'b1;
            end
            StSpDec: begin
                ALUSrcA = 2'd2;
                ALUSrcB = SrcBSpStep;
                ALUOp   = AluSub;
                SPWrite = 1'b1;
            end
            StPushWr: begin
                MemAddrSrc = 2'd3;
                MemWrite   = 1'b1;
            end
            StPopRd: begin
                MemAddrSrc = 2'd3;
                MemRead    = 1'b1;
            end
            StPopWb: begin
                ACCWrite = 1'b1;
                ACCSrc   = 3'd1;
                ALUSrcA  = 2'd2;
                ALUSrcB  = SrcBSpStep;
                SPWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign Halted = halt_q;
    assign State  = state_q;

endmodule

// File: tb/tb_acc_multicycle_control.sv
// Directed self-checking bench for acc_multicycle_control.
module tb_acc_multicycle_control;

    logic       CLK = 1'b0;
    logic       reset;
    logic [3:0] Opcode;
`ifdef CTRL_MEMWAIT_EN
    logic       MemReady;
`endif
    logic       PCWrite, Branch, BneOrBeq, IRWrite, MemRead, MemWrite;
    logic       ACCWrite, SPWrite, IOWrite, Halted;
    logic [1:0] PCSrc, MemAddrSrc, ALUSrcA;
    logic [2:0] ACCSrc, ALUSrcB, ALUOp;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    acc_multicycle_control dut (
        .CLK        (CLK),
        .reset      (reset),
        .Opcode     (Opcode),
`ifdef CTRL_MEMWAIT_EN
        .MemReady   (MemReady),
`endif
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .BneOrBeq   (BneOrBeq),
        .PCSrc      (PCSrc),
        .IRWrite    (IRWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemAddrSrc (MemAddrSrc),
        .ACCSrc     (ACCSrc),
        .ACCWrite   (ACCWrite),
        .SPWrite    (SPWrite),
        .IOWrite    (IOWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .Halted     (Halted),
        .State      (State)
    );

    always #5 CLK = ~CLK;

    wire [24:0] ctrl = {PCWrite, Branch, BneOrBeq, PCSrc, IRWrite, MemRead, MemWrite,
                        MemAddrSrc, ACCSrc, ACCWrite, SPWrite, IOWrite, ALUSrcA, ALUSrcB,
                        ALUOp, Halted};
    wire [7:0] enables = {PCWrite, Branch, IRWrite, MemRead, MemWrite, ACCWrite, SPWrite,
                          IOWrite};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset  = 1'b0;
        Opcode = 4'h0;
`ifdef CTRL_MEMWAIT_EN
        MemReady = 1'b1;
`endif
        repeat (2) tick();
        chk("rst_state", 32'(State), 0);
        chk("rst_ctrl", 32'(ctrl), 0);
        reset = 1'b1;

        // ADD: 1,2,3,4,1
        tick();
        chk("fetch_state", 32'(State), 1);
        chk("fetch_en", 32'({PCWrite, IRWrite, MemRead, MemWrite}), 32'b1110);
        chk("fetch_alu", 32'({ALUSrcA, ALUSrcB, ALUOp, MemAddrSrc}), 0);
        tick();
        chk("dec_state", 32'(State), 2);
        chk("dec_srcb", 32'({ALUSrcB, PCWrite, Branch}), 32'b011_0_0);
        tick();
        chk("add_memrd", 32'({State, MemRead, MemAddrSrc}), 32'b0011_1_10);
        tick();
        chk("add_exec_state", 32'(State), 4);
        chk("add_exec", 32'({ALUOp, ALUSrcA, ALUSrcB, ACCWrite, ACCSrc}), 32'b000_01_001_1_000);
        Opcode = 4'h9;
        tick();
        chk("add_ret", 32'(State), 1);

        // BNE: 1,2,8,1
        tick();
        tick();
        chk("bne_state", 32'(State), 8);
        chk("bne_ctrl", 32'({Branch, BneOrBeq, PCSrc, PCWrite, ALUOp, ALUSrcB}),
            32'b1_1_10_0_011_101);
        Opcode = 4'h8;
        tick();
        chk("bne_ret", 32'(State), 1);

        // BEQ polarity
        tick();
        tick();
        chk("beq_ctrl", 32'({State, Branch, BneOrBeq}), 32'b1000_1_0);
        Opcode = 4'h1;
        tick();

        // SUB uses ALUOp 1
        tick();
        tick();
        tick();
        chk("sub_exec", 32'({State, ALUOp, ACCSrc, ACCWrite}), 32'b0100_001_000_1);
        Opcode = 4'h6;
        tick();

        // EXEC_IMM: 3-cycle instruction
        tick();
        tick();
        chk("imm_exec", 32'({State, ALUSrcA, ALUSrcB, ACCWrite}), 32'b0110_01_010_1);
        Opcode = 4'hD;
        tick();
        chk("imm_ret", 32'(State), 1);

        // PUSH: 12, 13
        tick();
        tick();
        chk("push_dec", 32'({State, SPWrite, ALUOp, ALUSrcA, ALUSrcB}), 32'b1100_1_001_10_000);
        tick();
        chk("push_wr", 32'({State, MemAddrSrc, MemWrite, MemRead}), 32'b1101_11_1_0);
        Opcode = 4'hE;
        tick();
        chk("push_ret", 32'(State), 1);

        // POP: 14, 15
        tick();
        tick();
        chk("pop_rd", 32'({State, MemAddrSrc, MemRead, MemWrite}), 32'b1110_11_1_0);
        tick();
        chk("pop_wb", 32'({State, ACCSrc, ACCWrite, SPWrite, ALUOp, ALUSrcA}),
            32'b1111_001_1_1_000_10);
        Opcode = 4'h4;
        tick();
        chk("pop_ret", 32'(State), 1);

        // LOAD aborted by reset in MEM_RD
        tick();
        tick();
        chk("load_memrd", 32'(State), 3);
        reset = 1'b0;
        tick();
        chk("abort_state", 32'(State), 0);
        chk("abort_nowrite", 32'(ACCWrite), 0);
        reset = 1'b1;
        tick();
        chk("abort_fetch", 32'(State), 1);

        // Full LOAD selects MDR
        tick();
        tick();
        tick();
        chk("load_exec", 32'({State, ACCSrc, ACCWrite}), 32'b0100_001_1);
        Opcode = 4'hF;
        tick();

        // HALT
        tick();
        tick();
        chk("halt_state", 32'({State, Halted}), 32'b0000_1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_hold", 32'({State, Halted, enables}), 32'b0000_1_00000000);
        end
        reset = 1'b0;
        tick();
        chk("halt_rst", 32'({State, Halted}), 0);
        reset = 1'b1;
        Opcode = 4'h0;
        tick();
        chk("halt_fetch", 32'(State), 1);

`ifdef CTRL_MEMWAIT_EN
        // MEM_RD stall: 3 not-ready edges keep State at 3 for 4 cycles.
        tick();
        tick();
        chk("wait_enter", 32'(State), 3);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_hold", 32'({State, MemRead}), 32'b0011_1);
        end
        MemReady = 1'b1;
        tick();
        chk("wait_exit", 32'(State), 4);
        tick();
        // FETCH stall gates PC and IR writes
        MemReady = 1'b0;
        #1;
        chk("wait_fetch", 32'({State, PCWrite, IRWrite, MemRead}), 32'b0001_0_0_1);
        tick();
        chk("wait_fetch_hold", 32'(State), 1);
        MemReady = 1'b1;
        #1;
        chk("wait_fetch_go", 32'({PCWrite, IRWrite}), 32'b11);
        tick();
        chk("wait_fetch_dec", 32'(State), 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
